// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle of the seven-segment scanner: BCD digit input,
// scan controls and the registered active-low segment/anode drives.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    en;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output digits,
        output en,
        output blank_lz,
        input  seg,
        input  an
    );

    modport slave (
        input  digits,
        input  en,
        input  blank_lz,
        output seg,
        output an
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver. A prescaler divides
// the clock into digit slots; each slot starts with one dark cycle so the
// previous digit's segments never ghost onto the next anode. Leading zeros
// can optionally be suppressed without changing the slot timing.
module seven_seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scanner_if.slave   bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt;
    logic [SEL_W-1:0]      sel;
    logic                  slot_end;
    logic [3:0]            digit_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blanked;
    logic [3:0]            cur_digit;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;

    // Active-low segment pattern (g..a); anything outside 0-9 shows a dash.
    function automatic logic [6:0] decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b0111111;
        endcase
        return pattern;
    endfunction

    // The last enabled cycle of a slot produces the dark anti-ghosting cycle.
    assign slot_end = bus.en && (cnt == CNT_LAST);

    // Unpack the digits and mark leading zeros, scanning from the top digit down.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blanked    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_val[i] = bus.digits[4*i +: 4];
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (digit_val[i] == 4'd0);
            if (i > 0) begin
                blanked[i] = bus.blank_lz && upper_zero;
            end
        end
    end

    // Select the current digit and form the next anode/segment drive.
    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        an_next   = '1;
        seg_next  = 7'b1111111;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (SEL_W'(i) == sel) begin
                cur_digit = digit_val[i];
                cur_blank = blanked[i];
            end
        end
        if (!slot_end && !cur_blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_next[i] = (SEL_W'(i) != sel);
            end
            seg_next = decode(cur_digit);
        end
    end

    // Prescaler and digit select; both freeze while scanning is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sel <= '0;
        end else if (bus.en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Registered display drive, dark while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.an  <= '1;
            bus.seg <= 7'b1111111;
        end else begin
            bus.an  <= an_next;
            bus.seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with NUM_DIGITS=4, REFRESH_DIV=4.
// The reference model counts enabled cycles since reset and derives the slot
// and position within it arithmetically, then applies the display rules.
module tb_seven_seg_scanner;

    localparam int N   = 4;
    localparam int DIV = 4;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   ticks  = 0;

    seven_seg_scanner_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [N-1:0] exp_an,
                                input logic [6:0] exp_seg);
        checks++;
        assert (bus.an === exp_an) else begin
            errors++;
            $error("[TB] FAIL %s an: observed %b expected %b", tag, bus.an, exp_an);
        end
        checks++;
        assert (bus.seg === exp_seg) else begin
            errors++;
            $error("[TB] FAIL %s seg: observed %b expected %b", tag, bus.seg, exp_seg);
        end
    endtask

    // One clock: predict from the inputs seen at the edge, then compare.
    task automatic run_cycle(input string tag);
        logic [N-1:0] e_an;
        logic [6:0]   e_seg;
        logic [3:0]   dv;
        int           phase;
        int           d;
        phase = ticks % DIV;
        d     = (ticks / DIV) % N;
        dv    = 4'((bus.digits >> (4 * d)) & 16'hF);
        e_an  = '1;
        e_seg = 7'b1111111;
        if (!(bus.en && phase == DIV - 1) &&
            !(bus.blank_lz && d > 0 && (bus.digits >> (4 * d)) == 0)) begin
            e_an  = ~(N'(1) << d);
            e_seg = SEG_LUT[dv];
        end
        if (bus.en) ticks++;
        @(posedge clk);
        #1;
        check_output(tag, e_an, e_seg);
    endtask

    // Run with scanning enabled until the model reaches a slot/position.
    task automatic advance_to(input int slot, input int phase);
        int k;
        k = 0;
        bus.en = 1'b1;
        while (!(((ticks / DIV) % N == slot) && (ticks % DIV == phase)) && k < 4 * N * DIV) begin
            run_cycle("advance");
            k++;
        end
        checks++;
        assert (((ticks / DIV) % N == slot) && (ticks % DIV == phase)) else begin
            errors++;
            $error("[TB] FAIL advance_timeout: observed slot %0d expected %0d", (ticks / DIV) % N, slot);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.blank_lz = 1'b0;
        bus.digits   = 16'h0000;
        #1;
        check_output("reset_state", 4'b1111, 7'b1111111);
        @(posedge clk);
        #1;
        check_output("reset_held", 4'b1111, 7'b1111111);
        @(negedge clk);
        rst   = 1'b0;
        ticks = 0;

        // Plain scan of 1234.
        bus.digits = 16'h1234;
        bus.en     = 1'b1;
        run_cycle("scan_first");
        check_output("scan_first_const", 4'b1110, 7'b0011001);
        for (int i = 0; i < 2 * N * DIV; i++) run_cycle("scan_1234");

        // Leading-zero blanking of 0050, then all zeros.
        bus.digits   = 16'h0050;
        bus.blank_lz = 1'b1;
        advance_to(1, 0);
        run_cycle("lz_0050_d1");
        check_output("lz_0050_d1_const", 4'b1101, 7'b0010010);
        for (int i = 0; i < N * DIV; i++) run_cycle("lz_0050");
        bus.digits = 16'h0000;
        for (int i = 0; i < N * DIV; i++) run_cycle("lz_0000");
        advance_to(0, 1);
        run_cycle("lz_0000_d0");
        check_output("lz_0000_d0_const", 4'b1110, 7'b1000000);

        // Same value without blanking: upper zeros are shown.
        bus.digits   = 16'h0050;
        bus.blank_lz = 1'b0;
        advance_to(3, 1);
        run_cycle("nolz_d3");
        check_output("nolz_d3_const", 4'b0111, 7'b1000000);
        for (int i = 0; i < N * DIV; i++) run_cycle("nolz_0050");

        // Invalid BCD shows a dash and is never treated as a leading zero.
        bus.digits   = 16'h00A9;
        bus.blank_lz = 1'b1;
        advance_to(1, 1);
        run_cycle("dash_d1");
        check_output("dash_d1_const", 4'b1101, 7'b0111111);
        for (int i = 0; i < N * DIV; i++) run_cycle("dash_00A9");

        // Freeze mid-slot on digit 2 while its value changes.
        bus.digits   = 16'h0300;
        bus.blank_lz = 1'b0;
        advance_to(2, 1);
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) run_cycle("hold_3");
        bus.digits = 16'h0700;
        run_cycle("hold_7");
        check_output("hold_7_const", 4'b1011, 7'b1111000);
        for (int i = 0; i < 9; i++) run_cycle("hold_7");
        bus.en = 1'b1;
        for (int i = 0; i < N * DIV; i++) run_cycle("resume");

        // Disable exactly at the last cycle of a slot: no dark cycle, no advance.
        advance_to(1, DIV - 1);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle("hold_last");
        check_output("hold_last_const", 4'b1101, 7'b1111111 & SEG_LUT[0]);
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) run_cycle("resume_last");

        // Asynchronous reset between edges during the digit-3 slot.
        bus.digits = 16'h1234;
        advance_to(3, 2);
        #3;
        rst = 1'b1;
        #1;
        check_output("async_rst", 4'b1111, 7'b1111111);
        @(posedge clk);
        #1;
        check_output("async_rst_held", 4'b1111, 7'b1111111);
        @(negedge clk);
        rst   = 1'b0;
        ticks = 0;
        run_cycle("post_rst_1");
        check_output("post_rst_1_const", 4'b1110, 7'b0011001);
        for (int i = 0; i < 2 * DIV; i++) run_cycle("post_rst");

        // Randomized segments: random digits, blanking and enable.
        for (int r = 0; r < 10; r++) begin
            logic [15:0] val;
            val = '0;
            for (int n = 0; n < N; n++) begin
                if ($urandom_range(0, 2) != 0) begin
                    val = val | (16'($urandom_range(0, 15)) << (4 * n));
                end
            end
            bus.digits   = val;
            bus.blank_lz = 1'($urandom_range(0, 1));
            for (int c = 0; c < N * DIV; c++) begin
                bus.en = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 7) == 0) bus.digits = 16'($urandom);
                run_cycle("random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
